elevator_scan_ctrl: RTL and testbench

Parametrised elevator controller for N floors. Per-floor call requests are latched into a pending bitmap and served in SCAN order: keep travelling in the current direction while requests remain ahead, then reverse. Travel time per floor and door dwell time come from tick counters. Outputs drive the existing HEX, VGA and LED display paths through floor_o, plus a one-hot LED vector.

---
 rtl/elev_pkg.sv | 28 ++
 rtl/elev_pending_scan.sv | 33 +++
 rtl/elevator_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | elev_pkg                                                           |
// | Shared types and helpers for the SCAN elevator controller.         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package elev_pkg;

  // Controller states: idle, travelling between floors, door open.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest floor vector the one-hot helper can produce.
  localparam int unsigned MAX_FLOORS = 64;

  // One-hot decode of a floor index; callers truncate to their width.
  function automatic logic [MAX_FLOORS-1:0] onehot(input int unsigned idx);
    onehot = {{(MAX_FLOORS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/elev_pending_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | elev_pending_scan                                                  |
// | Reduces the pending-call bitmap against the current floor into     |
// | "request above", "request below" and "request here" flags.         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module elev_pending_scan #(
  parameter int unsigned N_FLOORS = 8,
  parameter int unsigned FLOOR_W  = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]  floor_idx,
  output logic                any_above,
  output logic                any_below,
  output logic                here
);

  logic [N_FLOORS-1:0] above_mask;
  logic [N_FLOORS-1:0] below_mask;

  // Per-floor masks: which floors lie strictly above / below the cab.
  for (genvar i = 0; i < N_FLOORS; i++) begin : g_mask
    assign above_mask[i] = (FLOOR_W'(i) > floor_idx);
    assign below_mask[i] = (FLOOR_W'(i) < floor_idx);
  end

  assign any_above = |(pending & above_mask);
  assign any_below = |(pending & below_mask);
  assign here      = pending[floor_idx];

endmodule
`default_nettype wire

// File: rtl/elevator_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | elevator_scan_ctrl                                                 |
// | N-floor elevator controller. Calls are latched into a pending      |
// | bitmap and served in SCAN order (continue while requests remain    |
// | ahead, then reverse). Travel and door dwell are tick-counted.      |
// | floor_o is 0-based; the HEX/VGA display paths show floor_o+1.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module elevator_scan_ctrl
  import elev_pkg::*;
#(
  parameter int unsigned N_FLOORS   = 8,
  parameter int unsigned FLOOR_W    = $clog2(N_FLOORS),
  parameter int unsigned MOVE_TICKS = 250_000_000,
  parameter int unsigned DOOR_TICKS = 100_000_000,
  parameter int unsigned CNT_W      = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]  floor_o,
  output logic                dir_up_o,
  output logic                moving_o,
  output logic                door_open_o,
  output logic [N_FLOORS-1:0] pending_o,
  output logic [N_FLOORS-1:0] led_o
);

  localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

  // Floor index to a one-hot vector of this controller's width.
  function automatic logic [N_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] idx);
    return N_FLOORS'(onehot(32'(idx)));
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic [FLOOR_W-1:0]  floor_q;
  logic [FLOOR_W-1:0]  floor_nxt;
  logic                dir_q;
  logic                dir_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [N_FLOORS-1:0] pending;
  logic [N_FLOORS-1:0] clr;
  logic [N_FLOORS-1:0] led_q;

  logic                any_above;
  logic                any_below;
  logic                here;
  logic                req_ahead;
  logic                req_behind;
  logic [FLOOR_W-1:0]  step_floor;

  elev_pending_scan #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_scan (
    .pending   (pending),
    .floor_idx (floor_q),
    .any_above (any_above),
    .any_below (any_below),
    .here      (here)
  );

  // "Ahead" and "behind" relative to the current travel direction.
  assign req_ahead  = dir_q ? any_above : any_below;
  assign req_behind = dir_q ? any_below : any_above;

  // Neighbouring floor in the travel direction; only used when a request
  // lies strictly ahead, so it never leaves 0..N_FLOORS-1.
  assign step_floor = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath-next logic for the SCAN sequencing.
  always_comb begin
    state_nxt = state;
    floor_nxt = floor_q;
    dir_nxt   = dir_q;
    cnt_nxt   = cnt_q;
    clr       = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (here) begin
          state_nxt = DOOR;
          clr       = floor_onehot(floor_q);
        end else if (any_above) begin
          dir_nxt   = DIR_UP;
          state_nxt = MOVE;
        end else if (any_below) begin
          dir_nxt   = DIR_DN;
          state_nxt = MOVE;
        end
      end
      MOVE: begin
        if (cnt_q == MOVE_LAST) begin
          cnt_nxt   = '0;
          floor_nxt = step_floor;
          // A call arriving on the very cycle we reach the floor still stops us.
          if (pending[step_floor] || call_req[step_floor]) begin
            state_nxt = DOOR;
            clr       = floor_onehot(step_floor);
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      DOOR: begin
        // Calls for the floor we are standing at are absorbed, never latched.
        clr = floor_onehot(floor_q);
        if (call_req[floor_q]) begin
          cnt_nxt = '0;
        end else if (cnt_q == DOOR_LAST) begin
          cnt_nxt = '0;
          if (req_ahead) begin
            state_nxt = MOVE;
          end else if (req_behind) begin
            dir_nxt   = ~dir_q;
            state_nxt = MOVE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers: floor, direction, tick counter, pending bitmap, LEDs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      floor_q <= '0;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      pending <= '0;
      led_q   <= N_FLOORS'(1);
    end else begin
      floor_q <= floor_nxt;
      dir_q   <= dir_nxt;
      cnt_q   <= cnt_nxt;
      pending <= (pending | call_req) & ~clr;
      led_q   <= floor_onehot(floor_q);
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    moving_o    = 1'b0;
    door_open_o = 1'b0;
    case (state)
      MOVE:    moving_o    = 1'b1;
      DOOR:    door_open_o = 1'b1;
      default: begin
        moving_o    = 1'b0;
        door_open_o = 1'b0;
      end
    endcase
  end

  assign floor_o   = floor_q;
  assign dir_up_o  = dir_q;
  assign pending_o = pending;
  assign led_o     = led_q;

  // The cab stays within the building.
  a_floor_range : assert property (@(posedge clk) disable iff (!rst_n)
    floor_q <= TOP_FLOOR);

  // Travel only happens towards an outstanding request.
  a_move_has_target : assert property (@(posedge clk) disable iff (!rst_n)
    (state == MOVE) |-> req_ahead);

endmodule
`default_nettype wire

// File: tb/tb_elevator_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_elevator_scan_ctrl                                              |
// | Scenario bench for the SCAN elevator controller (8 floors,         |
// | 4-tick travel, 3-tick door). Expected stops are queued when calls  |
// | are issued and matched against door openings.                      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_elevator_scan_ctrl;

  localparam int NF = 8;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] call_req = '0;
  logic [FW-1:0] floor_o;
  logic          dir_up_o;
  logic          moving_o;
  logic          door_open_o;
  logic [NF-1:0] pending_o;
  logic [NF-1:0] led_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of floors where the door is expected to open, in order.
  logic [FW-1:0] exp_q[$];

  always #5 clk = ~clk;

  elevator_scan_ctrl #(
    .N_FLOORS   (NF),
    .FLOOR_W    (FW),
    .MOVE_TICKS (4),
    .DOOR_TICKS (3),
    .CNT_W      (28)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .call_req    (call_req),
    .floor_o     (floor_o),
    .dir_up_o    (dir_up_o),
    .moving_o    (moving_o),
    .door_open_o (door_open_o),
    .pending_o   (pending_o),
    .led_o       (led_o)
  );

  task automatic apply_reset();
    rst_n    = 1'b0;
    call_req = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_call(input logic [NF-1:0] mask);
    call_req = mask;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (floor_o !== 3'd0) begin n_fail++; $display("FAIL reset_floor: got %0d want 0", floor_o); end
    n_checks++; if (dir_up_o !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b want 1", dir_up_o); end
    n_checks++; if (pending_o !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h want 00", pending_o); end
    n_checks++; if (moving_o !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b want 0", moving_o); end
    n_checks++; if (door_open_o !== 1'b0) begin n_fail++; $display("FAIL reset_door: got %b want 0", door_open_o); end
    n_checks++; if (led_o !== 8'h01) begin n_fail++; $display("FAIL reset_led: got %h want 01", led_o); end
  endtask

  task automatic test_single_call();
    logic [FW-1:0] e;
    pulse_call(8'h04);
    exp_q.push_back(3'd2);
    n_checks++; if (pending_o[2] !== 1'b1) begin n_fail++; $display("FAIL single_latch: pending[2]=%b want 1", pending_o[2]); end
    n_checks++; if (moving_o !== 1'b0) begin n_fail++; $display("FAIL single_not_yet_moving: got %b want 0", moving_o); end
    @(negedge clk);
    n_checks++; if (moving_o !== 1'b1) begin n_fail++; $display("FAIL single_move_start: got %b want 1", moving_o); end
    repeat (4) @(negedge clk);
    n_checks++; if (floor_o !== 3'd1) begin n_fail++; $display("FAIL single_floor1: got %0d want 1", floor_o); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (door_open_o !== 1'b1) begin
      n_fail++; $display("FAIL single_door_open: got %b want 1", door_open_o);
    end else begin
      e = exp_q.pop_front();
      if (floor_o !== e) begin n_fail++; $display("FAIL single_stop_floor: got %0d want %0d", floor_o, e); end
    end
    n_checks++; if (pending_o[2] !== 1'b0) begin n_fail++; $display("FAIL single_clear: pending[2]=%b want 0", pending_o[2]); end
    repeat (3) @(negedge clk);
    n_checks++; if ({moving_o, door_open_o} !== 2'b00) begin n_fail++; $display("FAIL single_idle: moving/door=%b want 00", {moving_o, door_open_o}); end
    n_checks++; if (led_o !== 8'h04) begin n_fail++; $display("FAIL single_led: got %h want 04", led_o); end
  endtask

  task automatic test_scan_up();
    logic [FW-1:0] e;
    logic prev_door;
    bit dir_ok;
    bit done;
    apply_reset();
    pulse_call(8'h28);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd5);
    prev_door = 1'b0; dir_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (moving_o && !dir_up_o) dir_ok = 1'b0;
      if (door_open_o && !prev_door) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL scan_up_stop: unexpected stop at %0d, none expected", floor_o);
        end else begin
          e = exp_q.pop_front();
          if (floor_o !== e) begin n_fail++; $display("FAIL scan_up_stop: got %0d want %0d", floor_o, e); end
        end
      end
      prev_door = door_open_o;
      if (exp_q.size() == 0 && !door_open_o && !moving_o) begin done = 1'b1; break; end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL scan_up_timeout: done=%b want 1", done); end
    n_checks++; if (!dir_ok) begin n_fail++; $display("FAIL scan_up_dir: dir went down (ok=%b) want 1", dir_ok); end
    n_checks++; if (floor_o !== 3'd5) begin n_fail++; $display("FAIL scan_up_final: got %0d want 5", floor_o); end
  endtask

  task automatic test_reverse();
    logic [FW-1:0] e;
    logic prev_door;
    bit injected;
    bit done;
    apply_reset();
    pulse_call(8'h50);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd1);
    prev_door = 1'b0; injected = 1'b0; done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      call_req = '0;
      if (!injected && moving_o && floor_o == 3'd4) begin
        call_req = 8'h02;
        injected = 1'b1;
      end
      if (door_open_o && !prev_door) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL reverse_stop: unexpected stop at %0d, none expected", floor_o);
        end else begin
          e = exp_q.pop_front();
          if (floor_o !== e) begin n_fail++; $display("FAIL reverse_stop: got %0d want %0d", floor_o, e); end
          if (e == 3'd6) begin
            n_checks++;
            if (dir_up_o !== 1'b1) begin n_fail++; $display("FAIL reverse_dir_at6: got %b want 1", dir_up_o); end
          end
        end
      end
      prev_door = door_open_o;
      if (injected && exp_q.size() == 0 && !door_open_o && !moving_o) begin done = 1'b1; break; end
    end
    call_req = '0;
    n_checks++; if (!done) begin n_fail++; $display("FAIL reverse_timeout: done=%b want 1", done); end
    n_checks++; if (dir_up_o !== 1'b0) begin n_fail++; $display("FAIL reverse_dir_final: got %b want 0", dir_up_o); end
    n_checks++; if (floor_o !== 3'd1) begin n_fail++; $display("FAIL reverse_final: got %0d want 1", floor_o); end
  endtask

  task automatic test_door_hold();
    logic [FW-1:0] e;
    bit opened;
    apply_reset();
    pulse_call(8'h04);
    exp_q.push_back(3'd2);
    opened = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (door_open_o) begin opened = 1'b1; break; end
    end
    n_checks++;
    if (!opened) begin
      n_fail++; $display("FAIL hold_door_timeout: opened=%b want 1", opened);
    end else begin
      e = exp_q.pop_front();
      if (floor_o !== e) begin n_fail++; $display("FAIL hold_stop_floor: got %0d want %0d", floor_o, e); end
    end
    call_req = 8'h04;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (door_open_o !== 1'b1 || pending_o[2] !== 1'b0) begin
        n_fail++; $display("FAIL hold_open: door=%b pending[2]=%b want 1/0 (cycle %0d)", door_open_o, pending_o[2], c);
      end
    end
    call_req = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (door_open_o !== 1'b1) begin n_fail++; $display("FAIL hold_release_open: got %b want 1", door_open_o); end
    @(negedge clk);
    n_checks++; if (door_open_o !== 1'b0) begin n_fail++; $display("FAIL hold_release_close: got %b want 0", door_open_o); end
    n_checks++; if (pending_o !== 8'h00) begin n_fail++; $display("FAIL hold_pending: got %h want 00", pending_o); end
  endtask

  task automatic test_reset_mid_move();
    bit reached;
    apply_reset();
    pulse_call(8'h40);
    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (moving_o && floor_o == 3'd3) begin reached = 1'b1; break; end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL midreset_reach3: reached=%b want 1", reached); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (floor_o !== 3'd0) begin n_fail++; $display("FAIL midreset_floor: got %0d want 0", floor_o); end
    n_checks++; if (pending_o !== 8'h00) begin n_fail++; $display("FAIL midreset_pending: got %h want 00", pending_o); end
    n_checks++; if (moving_o !== 1'b0) begin n_fail++; $display("FAIL midreset_moving: got %b want 0", moving_o); end
    n_checks++; if (led_o !== 8'h01) begin n_fail++; $display("FAIL midreset_led: got %h want 01", led_o); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({moving_o, door_open_o} !== 2'b00) begin n_fail++; $display("FAIL midreset_stays_idle: moving/door=%b want 00", {moving_o, door_open_o}); end
  endtask

  task automatic test_top_floor();
    logic [FW-1:0] e;
    logic prev_door;
    bit done;
    apply_reset();
    pulse_call(8'h80);
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (floor_o == 3'd7 && !door_open_o && !moving_o) begin done = 1'b1; break; end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL top_reach7: done=%b want 1", done); end
    pulse_call(8'h81);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    @(negedge clk);
    n_checks++;
    if (door_open_o !== 1'b1) begin
      n_fail++; $display("FAIL top_door_now: got %b want 1", door_open_o);
    end else begin
      e = exp_q.pop_front();
      if (floor_o !== e) begin n_fail++; $display("FAIL top_stop7: got %0d want %0d", floor_o, e); end
    end
    n_checks++; if (pending_o !== 8'h01) begin n_fail++; $display("FAIL top_pending: got %h want 01", pending_o); end
    prev_door = door_open_o; done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (door_open_o && !prev_door) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL top_stop: unexpected stop at %0d, none expected", floor_o);
        end else begin
          e = exp_q.pop_front();
          if (floor_o !== e) begin n_fail++; $display("FAIL top_stop: got %0d want %0d", floor_o, e); end
        end
      end
      prev_door = door_open_o;
      if (exp_q.size() == 0 && !door_open_o && !moving_o) begin done = 1'b1; break; end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL top_timeout: done=%b want 1", done); end
    n_checks++; if (floor_o !== 3'd0) begin n_fail++; $display("FAIL top_final: got %0d want 0", floor_o); end
    n_checks++; if (dir_up_o !== 1'b0) begin n_fail++; $display("FAIL top_dir: got %b want 0", dir_up_o); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_up();
    test_reverse();
    test_door_hold();
    test_reset_mid_move();
    test_top_floor();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
